// File: rtl/serial_rx.sv
// -----------------------------------------------------------------------------
// serial_rx
//   Receive end of the digit serial link. The transmitter's sclk, data_enable
//   and sdo arrive asynchronously; each is synchronised to clk, edges are
//   found with one history flop, and a three-state FSM shifts the bits into a
//   parallel word.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     sclk         serial clock from transmitter (async)
//     data_enable  frame enable, high while a word is shifted (async)
//     sdo          serial data, valid on sclk rising edge (async)
//     data_out     last complete word, held until the next good frame
//     data_valid   one-cycle pulse: data_out updated this cycle
//     frame_err    one-cycle pulse: frame ended with fewer than WIDTH bits
//     overrun      sticky: more than WIDTH sclk edges seen in a frame
//     busy         high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module serial_rx #(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 1,
  parameter int SYNC_STG  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             data_enable,
  input  logic             sdo,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STG-1:0] sclk_sync_q;
  logic [SYNC_STG-1:0] en_sync_q;
  logic [SYNC_STG-1:0] sdo_sync_q;
  logic                sclk_hist_q;
  logic                en_hist_q;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours; a blocking
  // assignment here would collapse the synchroniser chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      en_sync_q   <= '0;
      sdo_sync_q  <= '0;
      sclk_hist_q <= 1'b0;
      en_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
      en_sync_q   <= {en_sync_q[SYNC_STG-2:0], data_enable};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STG-2:0], sdo};
      sclk_hist_q <= sclk_sync_q[SYNC_STG-1];
      en_hist_q   <= en_sync_q[SYNC_STG-1];
    end
  end

  logic sclk_s, en_s, sdo_s;
  logic sclk_rise, en_rise, en_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign en_s      = en_sync_q[SYNC_STG-1];
  assign sdo_s     = sdo_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign en_rise   = en_s & ~en_hist_q;
  assign en_fall   = ~en_s & en_hist_q;

  // ---------------------------------------------------------------------------
  // Shift-register next value; bit order chosen by MSB_FIRST
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST != 0) begin
      shift_d = {shift_q[WIDTH-2:0], sdo_s};
    end else begin
      shift_d = {sdo_s, shift_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             extra_q;    // an extra sclk edge was seen in this frame
  logic             busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      extra_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // An sclk edge coinciding with en rise is deliberately not sampled.
          if (en_rise) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            extra_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // en fall has priority over a simultaneous sclk edge.
          if (en_fall) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else if (sclk_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_IDX) begin
              state_q <= FULL;
            end
          end
        end
        FULL: begin
          if (en_fall) begin
            data_out_q   <= shift_q;
            data_valid_q <= 1'b1;
            // A clean frame clears a stale overrun from an earlier frame.
            if (!extra_q) begin
              overrun_q <= 1'b0;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sclk_rise) begin
            extra_q   <= 1'b1;
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
